// File: rtl/cus19_jtype_pc_sequencer.sv
// rtl/cus19_jtype_pc_sequencer.sv - Custom-19 PC sequencer: JUMP/CALL/RET with a return-address stack.
// Optional stack-fault trap is enabled by defining CUS19_RAS_TRAP_EN.
module cus19_jtype_pc_sequencer #(
  parameter int PC_Width    = 11,
  parameter int Instr_Width = 19,
  parameter int Stack_Depth = 8,
  parameter logic [PC_Width-1:0] TRAP_VEC = 11'h7F0
) (
  input  logic                               cus19_clk_in,
  input  logic                               cus19_rst_in,
  input  logic [Instr_Width-1:0]             instr_in,
  input  logic                               instr_valid_in,
  input  logic                               stall_in,
  input  logic                               fault_clr_in,
  output logic [PC_Width-1:0]                pc_out,
  output logic                               jump_taken_out,
  output logic [PC_Width-1:0]                ret_addr_out,
  output logic [$clog2(Stack_Depth+1)-1:0]   sp_out,
  output logic                               stack_full_out,
  output logic                               stack_empty_out,
  output logic                               fault_out
);

  localparam int SP_W = $clog2(Stack_Depth+1);

`ifdef CUS19_RAS_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  localparam logic [1:0] SUB_JUMP = 2'b00;
  localparam logic [1:0] SUB_CALL = 2'b01;
  localparam logic [1:0] SUB_RET  = 2'b10;

  state_t                state_q, state_d;
  logic [PC_Width-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]       sp_q, sp_d;
  logic                  jump_q, jump_d;
  logic [PC_Width-1:0]   ras_q [Stack_Depth];
  logic [PC_Width-1:0]   ras_d [Stack_Depth];

  logic                  accept;
  logic                  is_j;
  logic [1:0]            sub;
  logic [PC_Width-1:0]   target;
  logic [PC_Width-1:0]   pc_inc;
  logic [PC_Width-1:0]   top;
  logic                  full;
  logic                  empty;
  logic                  push_en;
  logic                  trap_hit;

  assign is_j   = (instr_in[2:0] == 3'b010) && (instr_in[18:16] == 3'b000);
  assign sub    = instr_in[4:3];
  assign target = instr_in[5 +: PC_Width];
  assign accept = instr_valid_in && !stall_in && (state_q == ST_RUN);
  assign pc_inc = pc_q + PC_Width'(1);
  assign full   = (sp_q == SP_W'(Stack_Depth));
  assign empty  = (sp_q == '0);

  // Top-of-stack read; an empty stack reads as zero.
  always_comb begin
    top = '0;
    for (int i = 0; i < Stack_Depth; i++) begin
      if (sp_q == SP_W'(i + 1)) top = ras_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    jump_d   = 1'b0;
    push_en  = 1'b0;
    trap_hit = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (is_j) begin
            case (sub)
              SUB_JUMP: begin
                pc_d   = target;
                jump_d = 1'b1;
              end
              SUB_CALL: begin
                if (full && TrapEn) begin
                  trap_hit = 1'b1;
                end else begin
                  pc_d   = target;
                  jump_d = 1'b1;
                  if (!full) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                  end
                end
              end
              SUB_RET: begin
                if (empty) begin
                  if (TrapEn) trap_hit = 1'b1;
                  else        pc_d     = pc_inc;
                end else begin
                  pc_d   = top;
                  sp_d   = sp_q - SP_W'(1);
                  jump_d = 1'b1;
                end
              end
              default: pc_d = pc_inc;
            endcase
          end else begin
            pc_d = pc_inc;
          end
        end
        if (trap_hit) begin
          pc_d    = TRAP_VEC;
          jump_d  = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (fault_clr_in) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    for (int i = 0; i < Stack_Depth; i++) begin
      ras_d[i] = ras_q[i];
      if (push_en && (sp_q == SP_W'(i))) ras_d[i] = pc_inc;
    end
  end

  always_ff @(posedge cus19_clk_in or posedge cus19_rst_in) begin
    if (cus19_rst_in) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      jump_q  <= 1'b0;
      for (int i = 0; i < Stack_Depth; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      jump_q  <= jump_d;
      for (int i = 0; i < Stack_Depth; i++) ras_q[i] <= ras_d[i];
    end
  end

  assign pc_out          = pc_q;
  assign jump_taken_out  = jump_q;
  assign ret_addr_out    = top;
  assign sp_out          = sp_q;
  assign stack_full_out  = full;
  assign stack_empty_out = empty;

`ifdef CUS19_RAS_TRAP_EN
  assign fault_out = (state_q == ST_FAULT);
`else
  assign fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_cus19_jtype_pc_sequencer.sv
// tb/tb_cus19_jtype_pc_sequencer.sv - Scoreboard bench for cus19_jtype_pc_sequencer.
module tb_cus19_jtype_pc_sequencer;

  localparam logic [10:0] TV  = 11'h7F0;
  localparam logic [18:0] ADD = 19'b0100001000110000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] instr_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        fault_clr_in = 1'b0;
  logic [10:0] pc_out;
  logic        jump_taken_out;
  logic [10:0] ret_addr_out;
  logic [3:0]  sp_out;
  logic        stack_full_out;
  logic        stack_empty_out;
  logic        fault_out;

  cus19_jtype_pc_sequencer dut (
    .cus19_clk_in    (clk),
    .cus19_rst_in    (rst),
    .instr_in        (instr_in),
    .instr_valid_in  (instr_valid_in),
    .stall_in        (stall_in),
    .fault_clr_in    (fault_clr_in),
    .pc_out          (pc_out),
    .jump_taken_out  (jump_taken_out),
    .ret_addr_out    (ret_addr_out),
    .sp_out          (sp_out),
    .stack_full_out  (stack_full_out),
    .stack_empty_out (stack_empty_out),
    .fault_out       (fault_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] pc;
    logic        j;
    logic [3:0]  sp;
    logic [10:0] ret;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  function automatic exp_t ex(input logic [10:0] pc, input logic j, input logic [3:0] sp,
                              input logic [10:0] ret, input logic f);
    exp_t e;
    e.pc = pc; e.j = j; e.sp = sp; e.ret = ret; e.f = f;
    return e;
  endfunction

  function automatic logic [18:0] jw(input logic [1:0] sub, input logic [10:0] t);
    return {3'b000, t, sub, 3'b010};
  endfunction

  task automatic issue(input logic [18:0] w, input logic v, input logic st, input logic clr,
                       input exp_t e);
    instr_in       = w;
    instr_valid_in = v;
    stall_in       = st;
    fault_clr_in   = clr;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    instr_valid_in = 1'b0;
    stall_in       = 1'b0;
    fault_clr_in   = 1'b0;
  endtask

  // Monitor: compares the registered state presented after each edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",    32'(pc_out),          32'(e.pc));
        check("jump",  32'(jump_taken_out),  32'(e.j));
        check("sp",    32'(sp_out),          32'(e.sp));
        check("ret",   32'(ret_addr_out),    32'(e.ret));
        check("fault", 32'(fault_out),       32'(e.f));
        check("full",  32'(stack_full_out),  32'(e.sp == 4'd8));
        check("empty", 32'(stack_empty_out), 32'(e.sp == 4'd0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [10:0] r [8];
    r[0] = 11'd9;   r[1] = 11'd17;  r[2] = 11'd33;  r[3] = 11'd49;
    r[4] = 11'd65;  r[5] = 11'd81;  r[6] = 11'd97;  r[7] = 11'd113;

    #12;
    check("rst_pc",    32'(pc_out), 0);
    check("rst_sp",    32'(sp_out), 0);
    check("rst_empty", 32'(stack_empty_out), 1);
    check("rst_jump",  32'(jump_taken_out), 0);
    check("rst_fault", 32'(fault_out), 0);
    @(negedge clk);
    rst = 1'b0;

    issue(jw(2'b00, 11'd5),  1, 0, 0, ex(11'd5, 1, 0, 0, 0));
    issue(19'd0,             0, 0, 0, ex(11'd5, 0, 0, 0, 0));
    issue(ADD,               1, 0, 0, ex(11'd6, 0, 0, 0, 0));
    issue(jw(2'b01, 11'd10), 1, 0, 0, ex(11'd10, 1, 1, 11'd7, 0));
    issue(ADD,               1, 0, 0, ex(11'd11, 0, 1, 11'd7, 0));
    issue(jw(2'b10, 11'd0),  1, 0, 0, ex(11'd7, 1, 0, 0, 0));
    issue(jw(2'b11, 11'd300),1, 0, 0, ex(11'd8, 0, 0, 0, 0));
    issue(jw(2'b01, 11'd20), 1, 1, 0, ex(11'd8, 0, 0, 0, 0));
    issue(19'd0,             0, 0, 1, ex(11'd8, 0, 0, 0, 0));

    for (int k = 0; k < 8; k++)
      issue(jw(2'b01, 11'(16 * (k + 1))), 1, 0, 0, ex(11'(16 * (k + 1)), 1, 4'(k + 1), r[k], 0));

`ifdef CUS19_RAS_TRAP_EN
    issue(jw(2'b01, 11'h200), 1, 0, 0, ex(TV, 1, 8, 11'd113, 1));
    issue(ADD,                1, 1, 0, ex(TV, 0, 8, 11'd113, 1));
    issue(ADD,                1, 0, 0, ex(TV, 0, 8, 11'd113, 1));
    issue(19'd0,              0, 0, 1, ex(TV, 0, 8, 11'd113, 0));
    issue(ADD,                1, 0, 0, ex(11'h7F1, 0, 8, 11'd113, 0));
`else
    issue(jw(2'b01, 11'h200), 1, 0, 0, ex(11'h200, 1, 8, 11'd113, 0));
    issue(19'd0,              0, 0, 1, ex(11'h200, 0, 8, 11'd113, 0));
    issue(ADD,                1, 0, 0, ex(11'h201, 0, 8, 11'd113, 0));
`endif

    for (int k = 7; k >= 0; k--)
      issue(jw(2'b10, 11'd0), 1, 0, 0, ex(r[k], 1, 4'(k), (k > 0) ? r[(k > 0) ? k - 1 : 0] : 11'd0, 0));

`ifdef CUS19_RAS_TRAP_EN
    issue(jw(2'b10, 11'd0), 1, 0, 0, ex(TV, 1, 0, 0, 1));
    issue(jw(2'b10, 11'd0), 1, 1, 0, ex(TV, 0, 0, 0, 1));
    issue(19'd0,            0, 0, 1, ex(TV, 0, 0, 0, 0));
`else
    issue(jw(2'b10, 11'd0), 1, 0, 0, ex(11'd10, 0, 0, 0, 0));
`endif

    issue(jw(2'b00, 11'd2047), 1, 0, 0, ex(11'h7FF, 1, 0, 0, 0));
    issue(jw(2'b01, 11'd5),    1, 0, 0, ex(11'd5, 1, 1, 11'd0, 0));
    issue(jw(2'b01, 11'd6),    1, 0, 0, ex(11'd6, 1, 2, 11'd6, 0));
    issue(jw(2'b01, 11'd7),    1, 0, 0, ex(11'd7, 1, 3, 11'd7, 0));

    @(negedge clk);
    #1;
    instr_in       = jw(2'b01, 11'd40);
    instr_valid_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc",    32'(pc_out), 0);
    check("async_rst_sp",    32'(sp_out), 0);
    check("async_rst_empty", 32'(stack_empty_out), 1);
    check("async_rst_ret",   32'(ret_addr_out), 0);
    check("async_rst_jump",  32'(jump_taken_out), 0);
    @(posedge clk);
    #1;
    check("rst_hold_pc", 32'(pc_out), 0);
    @(negedge clk);
    rst = 1'b0;
    instr_valid_in = 1'b0;
    issue(jw(2'b00, 11'd33), 1, 0, 0, ex(11'd33, 1, 0, 0, 0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
